// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the dual-lane fetch queue.
// Holds default widths, NOP encoding and thermometer lane masks.
package fetch_queue_pkg;
  localparam int FQ_XLEN  = 32;
  localparam int FQ_DEPTH = 8;
  localparam logic [FQ_XLEN-1:0] FQ_NOP = 32'h0000_0000;
  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_ONE  = 2'b01;
  localparam logic [1:0] LANE_TWO  = 2'b11;

  function automatic logic [1:0] popcnt2(
    input logic [1:0] m
  );
    return {1'b0, m[0]} + {1'b0, m[1]};
  endfunction
endpackage

// File: rtl/fq_storage.sv
// DEPTH x W register array, two write ports and two read ports.
// Ports: clk, reset (async low), we0/we1 + addr/data, raddr0/1 -> rdata0/1.
module fq_storage #(
  parameter int DEPTH = 8,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] waddr0,
  input  logic [AW-1:0] waddr1,
  input  logic [W-1:0]  wdata0,
  input  logic [W-1:0]  wdata1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1
);

  logic [W-1:0] r_mem [DEPTH];

  // waddr1 is always waddr0+1, so the two ports never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (we0) r_mem[waddr0] <= wdata0;
      if (we1) r_mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = r_mem[raddr0];
  assign rdata1 = r_mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Dual-lane instruction buffer between fetch and decode.
// In: clk, reset, flush, enq_*, deq_take. Out: enq_ready, deq_*, count.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int XLEN  = FQ_XLEN,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [1:0]      enq_valid,
  input  logic [XLEN-1:0] enq_instr0,
  input  logic [XLEN-1:0] enq_instr1,
  input  logic [XLEN-1:0] enq_pc0,
  input  logic [XLEN-1:0] enq_pc1,
  output logic            enq_ready,
  output logic [1:0]      deq_valid,
  output logic [XLEN-1:0] deq_instr0,
  output logic [XLEN-1:0] deq_instr1,
  output logic [XLEN-1:0] deq_pc0,
  output logic [XLEN-1:0] deq_pc1,
  input  logic [1:0]      deq_take,
  output logic [CW-1:0]   count
);

  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              w_enq_ready;
  logic [1:0]        w_enq_mask;
  logic [1:0]        w_enq_n;
  logic [1:0]        w_deq_valid;
  logic [1:0]        w_deq_n;
  logic [2*XLEN-1:0] w_rd0;
  logic [2*XLEN-1:0] w_rd1;

  // Conservative: free space judged before this cycle's dequeue
  assign w_enq_ready = (r_count <= CW'(DEPTH - 2));

  // Lane 1 only counts when lane 0 is valid
  assign w_enq_mask = enq_valid[0] ? enq_valid : LANE_NONE;
  assign w_enq_n    = w_enq_ready ? popcnt2(w_enq_mask) : 2'd0;

  assign w_deq_valid = (r_count == '0)     ? LANE_NONE :
                       (r_count == CW'(1)) ? LANE_ONE  :
                                             LANE_TWO;
  assign w_deq_n = popcnt2(deq_take & w_deq_valid);

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (2 * XLEN)
  ) u_storage (
    .clk    (clk),
    .reset  (reset),
    .we0    (w_enq_ready & w_enq_mask[0] & ~flush),
    .we1    (w_enq_ready & w_enq_mask[1] & ~flush),
    .waddr0 (r_tail),
    .waddr1 (r_tail + AW'(1)),
    .wdata0 ({enq_pc0, enq_instr0}),
    .wdata1 ({enq_pc1, enq_instr1}),
    .raddr0 (r_head),
    .raddr1 (r_head + AW'(1)),
    .rdata0 (w_rd0),
    .rdata1 (w_rd1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_n);
      r_tail  <= r_tail + AW'(w_enq_n);
      r_count <= r_count + CW'(w_enq_n)
                         - CW'(w_deq_n);
    end
  end

  assign enq_ready  = w_enq_ready;
  assign deq_valid  = w_deq_valid;
  assign count      = r_count;
  assign deq_instr0 = w_deq_valid[0] ? w_rd0[XLEN-1:0]
                                     : XLEN'(FQ_NOP);
  assign deq_instr1 = w_deq_valid[1] ? w_rd1[XLEN-1:0]
                                     : XLEN'(FQ_NOP);
  assign deq_pc0    = w_deq_valid[0] ? w_rd0[2*XLEN-1:XLEN]
                                     : '0;
  assign deq_pc1    = w_deq_valid[1] ? w_rd1[2*XLEN-1:XLEN]
                                     : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue model plus directed checks.
// Model is a FIFO of {pc,instr}; outputs compared every falling edge.
module tb_fetch_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [31:0] enq_instr0, enq_instr1;
  logic [31:0] enq_pc0, enq_pc1;
  logic        enq_ready;
  logic [1:0]  deq_valid;
  logic [31:0] deq_instr0, deq_instr1;
  logic [31:0] deq_pc0, deq_pc1;
  logic [1:0]  deq_take;
  logic [3:0]  count;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_instr0 (enq_instr0),
    .enq_instr1 (enq_instr1),
    .enq_pc0    (enq_pc0),
    .enq_pc1    (enq_pc1),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_instr0 (deq_instr0),
    .deq_instr1 (deq_instr1),
    .deq_pc0    (deq_pc0),
    .deq_pc1    (deq_pc1),
    .deq_take   (deq_take),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  int          n_pass;
  int          n_total;
  logic [31:0] npc;
  logic [31:0] exp_next;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  name, got, exp);
  endtask

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return 32'h1000_0000 ^ pc;
  endfunction

  // Model: FIFO semantics from the behavioural rules
  always @(negedge reset) mq.delete();

  always @(posedge clk) begin
    int sz;
    int dvn;
    int n;
    bit rdy;
    if (reset) begin
      if (flush) begin
        mq.delete();
      end else begin
        sz  = mq.size();
        rdy = (DEPTH - sz) >= 2;
        dvn = (sz >= 2) ? 2 : sz;
        n   = 0;
        if (deq_take[0] && dvn >= 1) n++;
        if (deq_take[1] && dvn >= 2) n++;
        for (int i = 0; i < n; i++) void'(mq.pop_front());
        if (rdy && enq_valid[0])
          mq.push_back('{enq_pc0, enq_instr0});
        if (rdy && enq_valid == 2'b11)
          mq.push_back('{enq_pc1, enq_instr1});
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = mq.size();
    chk("m_count", 64'(count), 64'(sz));
    chk("m_ready", 64'(enq_ready), 64'((DEPTH - sz) >= 2));
    chk("m_valid", 64'(deq_valid),
        64'((sz >= 2) ? 2'b11 : (sz == 1) ? 2'b01 : 2'b00));
    chk("m_lane0", {deq_pc0, deq_instr0},
        (sz >= 1) ? {mq[0].pc, mq[0].instr} : 64'h0);
    chk("m_lane1", {deq_pc1, deq_instr1},
        (sz >= 2) ? {mq[1].pc, mq[1].instr} : 64'h0);
  end

  // Drive one cycle at a falling edge, return at the next falling edge
  task automatic cyc(input logic [1:0] v,
                     input logic [1:0] take);
    enq_valid  = v;
    enq_pc0    = npc;
    enq_pc1    = npc + 32'd4;
    enq_instr0 = mk(npc);
    enq_instr1 = mk(npc + 32'd4);
    deq_take   = take;
    if (!flush && (DEPTH - mq.size()) >= 2)
      npc = npc + ((v == 2'b11) ? 32'd8 :
                   (v == 2'b01) ? 32'd4 : 32'd0);
    @(negedge clk);
    enq_valid = 2'b00;
    deq_take  = 2'b00;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; flush = 1'b0;
    enq_valid = 2'b00; deq_take = 2'b00;
    enq_instr0 = '0; enq_instr1 = '0;
    enq_pc0 = '0; enq_pc1 = '0;
    npc = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_valid", 64'(deq_valid), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_ready", 64'(enq_ready), 64'h1);
    chk("rst_instr0", 64'(deq_instr0), 64'h0);

    // 1: first pair
    enq_valid = 2'b11;
    enq_instr0 = 32'h2008_0005; enq_pc0 = 32'h0;
    enq_instr1 = 32'h2009_000C; enq_pc1 = 32'h4;
    @(negedge clk);
    enq_valid = 2'b00;
    npc = 32'h8;
    chk("t1_valid", 64'(deq_valid), 64'h3);
    chk("t1_instr0", 64'(deq_instr0), 64'h2008_0005);
    chk("t1_pc1", 64'(deq_pc1), 64'h4);
    chk("t1_count", 64'(count), 64'h2);

    // 2: fill
    repeat (3) cyc(2'b11, 2'b00);
    chk("t2_count", 64'(count), 64'h8);
    chk("t2_ready", 64'(enq_ready), 64'h0);
    cyc(2'b11, 2'b00);
    chk("t2_drop", 64'(count), 64'h8);
    chk("t2_pc0", 64'(deq_pc0), 64'h0);

    // 3: drain from full
    chk("t3_pcA", 64'(deq_pc0), 64'h0);
    cyc(2'b00, 2'b01);
    chk("t3_c7", 64'(count), 64'h7);
    chk("t3_rdy7", 64'(enq_ready), 64'h0);
    chk("t3_pcB", 64'(deq_pc0), 64'h4);
    chk("t3_pcC", 64'(deq_pc1), 64'h8);
    cyc(2'b00, 2'b11);
    chk("t3_c5", 64'(count), 64'h5);
    chk("t3_rdy5", 64'(enq_ready), 64'h1);
    chk("t3_pcD", 64'(deq_pc0), 64'hC);

    // 4: steady stream, pointers wrap several times
    exp_next = 32'hC;
    for (int i = 0; i < 20; i++) begin
      chk("t4_count", 64'(count), 64'h5);
      chk("t4_pc0", 64'(deq_pc0), 64'(exp_next));
      chk("t4_pc1", 64'(deq_pc1), 64'(exp_next + 32'd4));
      exp_next = exp_next + 32'd8;
      cyc(2'b11, 2'b11);
    end

    // 5: flush beats enqueue and dequeue
    chk("t5_pre", 64'(count), 64'h5);
    flush = 1'b1;
    cyc(2'b11, 2'b11);
    flush = 1'b0;
    chk("t5_count", 64'(count), 64'h0);
    chk("t5_valid", 64'(deq_valid), 64'h0);
    chk("t5_instr0", 64'(deq_instr0), 64'h0);

    // Empty queue ignores take
    cyc(2'b00, 2'b11);
    chk("empty_take", 64'(count), 64'h0);

    // 6: async reset mid-stream
    repeat (2) cyc(2'b11, 2'b00);
    chk("t6_pre", 64'(count), 64'h4);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid", 64'(deq_valid), 64'h0);
    chk("t6_count", 64'(count), 64'h0);
    @(negedge clk);
    reset = 1'b1;
    npc = 32'h100;
    cyc(2'b01, 2'b00);
    chk("t6_lane0", 64'(deq_pc0), 64'h100);
    chk("t6_instr", 64'(deq_instr0), 64'(mk(32'h100)));
    chk("t6_valid1", 64'(deq_valid), 64'h1);

    // Take beyond valid lanes only removes one
    cyc(2'b00, 2'b11);
    chk("over_take", 64'(count), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
